// File: rtl/synth_pkg.sv
// Shared constants for the keypad tone generator: key count, counter width,
// note period table (C4..D5 at 10 MHz) and the half-period helper.
package synth_pkg;

    localparam int NUM_KEYS = 15;
    localparam int CNT_W    = 16;

    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

    // Equal-tempered periods in clk cycles, round(1e7 / f), semitone k above C4
    localparam logic [CNT_W-1:0] NOTE_PERIOD [0:NUM_KEYS-1] = '{
        16'd38223, 16'd36077, 16'd34052, 16'd32141, 16'd30337,
        16'd28635, 16'd27027, 16'd25511, 16'd24079, 16'd22727,
        16'd21452, 16'd20248, 16'd19111, 16'd18039, 16'd17026
    };

    function automatic logic [CNT_W-1:0] half_period(input logic [CNT_W-1:0] n);
        return n >> 1;
    endfunction

endpackage

// File: rtl/tone_divider.sv
// Period counter and 50%-duty compare; output high for floor(N/2) cycles,
// then low for the rest of the N-cycle period.
module tone_divider
    import synth_pkg::*;
(
    input  logic             clk,
    input  logic             n_rst,
    input  logic             run,
    input  logic [CNT_W-1:0] period,
    input  logic             restart,
    output logic             pwm_o
);

    logic [CNT_W-1:0] cnt_r;
    logic [CNT_W-1:0] cnt_nxt_s;
    logic             pwm_nxt_s;

    // Next counter value and output level
    always_comb begin
        cnt_nxt_s = cnt_r;
        pwm_nxt_s = 1'b0;
        if (!run) begin
            cnt_nxt_s = CNT_ZERO;
            pwm_nxt_s = 1'b0;
        end else if (restart) begin
            cnt_nxt_s = CNT_ZERO;
            pwm_nxt_s = 1'b1;
        end else begin
            pwm_nxt_s = (cnt_r < half_period(period));
            // >= rather than == so a shorter note picked mid-period wraps at once
            if (cnt_r >= (period - CNT_ONE)) begin
                cnt_nxt_s = CNT_ZERO;
            end else begin
                cnt_nxt_s = cnt_r + CNT_ONE;
            end
        end
    end

    // Counter and output flops
    always_ff @(posedge clk) begin
        if (!n_rst) begin
            cnt_r <= CNT_ZERO;
            pwm_o <= 1'b0;
        end else begin
            cnt_r <= cnt_nxt_s;
            pwm_o <= pwm_nxt_s;
        end
    end

endmodule

// File: rtl/synth_top.sv
// Keypad square-wave synth top: priority-encodes the keypad, looks up the note
// period and drives tone_divider. Optional macro SYNTH_RESTART_EN restarts phase on key change.
module synth_top
    import synth_pkg::*;
(
    input  logic                clk,
    input  logic                n_rst,
    input  logic                en,
    input  logic [NUM_KEYS-1:0] keypad_i,
    output logic                pwm_o
);

    logic [3:0]       key_idx_s;
    logic             key_vld_s;
    logic [CNT_W-1:0] period_s;
    logic             run_s;
    logic             restart_s;

    // Lowest set keypad bit wins; index 15 means no key
    always_comb begin
        key_idx_s = 4'd15;
        key_vld_s = 1'b0;
        for (int k = NUM_KEYS - 1; k >= 0; k--) begin
            if (keypad_i[k]) begin
                key_idx_s = 4'(k);
                key_vld_s = 1'b1;
            end else begin
                key_vld_s = key_vld_s;
            end
        end
    end

    // Note period lookup
    always_comb begin
        if (key_vld_s) begin
            period_s = NOTE_PERIOD[key_idx_s];
        end else begin
            period_s = CNT_ZERO;
        end
    end

    assign run_s = en & key_vld_s;

`ifdef SYNTH_RESTART_EN
    logic [3:0] prev_sel_r;

    // Selection seen on the previous edge, 15 = none
    always_ff @(posedge clk) begin
        if (!n_rst) begin
            prev_sel_r <= 4'd15;
        end else begin
            prev_sel_r <= key_idx_s;
        end
    end

    assign restart_s = (key_idx_s != prev_sel_r);
`else
    assign restart_s = 1'b0;
`endif

    tone_divider u_div (
        .clk     (clk),
        .n_rst   (n_rst),
        .run     (run_s),
        .period  (period_s),
        .restart (restart_s),
        .pwm_o   (pwm_o)
    );

endmodule

// File: tb/tb_synth_top.sv
// Self-checking bench for synth_top: vector table, long-period sequences,
// and randomized stimulus against a behavioural model.
module tb_synth_top;

    logic        tb_clk;
    logic        n_rst;
    logic        en;
    logic [14:0] keypad;
    logic        pwm;

    int checks = 0;
    int errors = 0;

    int per_tab [15] = '{38223, 36077, 34052, 32141, 30337, 28635, 27027,
                         25511, 24079, 22727, 21452, 20248, 19111, 18039, 17026};

    typedef struct {
        logic        en;
        logic [14:0] kp;
        int          ncyc;
        logic        exp;
    } vec_t;

    vec_t tbl [11];

    int m_pos;
    logic m_out;
    int m_prev;

    synth_top dut (
        .clk      (tb_clk),
        .n_rst    (n_rst),
        .en       (en),
        .keypad_i (keypad),
        .pwm_o    (pwm)
    );

    initial tb_clk = 1'b0;
    always #50 tb_clk = ~tb_clk;

    task automatic step();
        @(posedge tb_clk);
        #1;
    endtask

    task automatic check_bit(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0b expected %0b", name, act, exp);
        end
    endtask

    task automatic check_int(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Count consecutive samples at level lvl, starting with the current one
    task automatic run_len(input logic lvl, input int limit, output int n);
        n = 0;
        while (pwm === lvl && n < limit) begin
            n++;
            step();
        end
    endtask

    task automatic silence(input logic [14:0] kp);
        en = 1'b0;
        keypad = kp;
        step();
        check_bit("silence", pwm, 1'b0);
    endtask

    // Reference: spec rules on an integer phase position
    task automatic model_edge(input logic r, input logic e, input logic [14:0] kp);
        int sel;
        int n;
        sel = 15;
        for (int k = 14; k >= 0; k--) if (kp[k]) sel = k;
        if (!r) begin
            m_pos = 0; m_out = 1'b0; m_prev = 15;
        end else begin
            if (!e || sel == 15) begin
                m_pos = 0; m_out = 1'b0;
            end
`ifdef SYNTH_RESTART_EN
            else if (sel != m_prev) begin
                m_pos = 0; m_out = 1'b1;
            end
`endif
            else begin
                n = per_tab[sel];
                m_out = (m_pos < n / 2);
                m_pos = (m_pos >= n - 1) ? 0 : m_pos + 1;
            end
            m_prev = sel;
        end
    endtask

    initial begin
        int n;
        int bad;
        int cyc;
        int seglen;
        int k;
        logic r_s;
        logic e_s;
        logic [14:0] kp_s;
        logic [14:0] hi;

        tbl[0]  = '{1'b0, 15'h0001, 3,    1'b0};
        tbl[1]  = '{1'b1, 15'h0000, 5,    1'b0};
        tbl[2]  = '{1'b1, 15'h0001, 1,    1'b1};
        tbl[3]  = '{1'b1, 15'h0001, 20,   1'b1};
        tbl[4]  = '{1'b0, 15'h0001, 1,    1'b0};
        tbl[5]  = '{1'b1, 15'h0001, 1,    1'b1};
        tbl[6]  = '{1'b1, 15'h0000, 1,    1'b0};
        tbl[7]  = '{1'b1, 15'h4000, 1,    1'b1};
        tbl[8]  = '{1'b1, 15'h1001, 9600, 1'b1};
`ifdef SYNTH_RESTART_EN
        tbl[9]  = '{1'b1, 15'h1000, 1,    1'b1};
`else
        tbl[9]  = '{1'b1, 15'h1000, 1,    1'b0};
`endif
        tbl[10] = '{1'b0, 15'h1000, 1,    1'b0};

        // Reset held with a key pressed and enable high
        n_rst = 1'b0; en = 1'b1; keypad = 15'h0001;
        step(); check_bit("reset_c1", pwm, 1'b0);
        step(); check_bit("reset_c2", pwm, 1'b0);
        n_rst = 1'b1; en = 1'b0;
        bad = 0;
        for (int i = 0; i < 3; i++) begin
            step();
            if (pwm !== 1'b0) bad++;
        end
        check_int("post_reset_en0", bad, 0);

        for (int i = 0; i < 11; i++) begin
            en = tbl[i].en;
            keypad = tbl[i].kp;
            for (int c = 0; c < tbl[i].ncyc; c++) step();
            check_bit($sformatf("vec%0d", i), pwm, tbl[i].exp);
        end

        // Low C, then switch to D5 with the counter near 30000
        silence(15'h0001);
        en = 1'b1;
        step();
        check_bit("lowC_first_edge", pwm, 1'b1);
        run_len(1'b1, 19200, n);
        check_int("lowC_high_len", n, 19111);
        bad = 0;
        for (int i = 0; i < 10888; i++) begin
            if (pwm !== 1'b0) bad++;
            step();
        end
        check_int("lowC_low_hold", bad, 0);
        keypad = 15'h4000;
        step();
`ifdef SYNTH_RESTART_EN
        check_bit("keychg_edge", pwm, 1'b1);
        run_len(1'b1, 8600, n);
        check_int("keychg_high_len", n, 8514);
`else
        check_bit("keychg_edge", pwm, 1'b0);
        step();
        check_bit("keychg_wrap", pwm, 1'b1);
        run_len(1'b1, 8600, n);
        check_int("keychg_high_len", n, 8513);
`endif
        run_len(1'b0, 8600, n);
        check_int("keychg_low_len", n, 8513);

        // A4 full period
        silence(15'h0200);
        en = 1'b1;
        step();
        run_len(1'b1, 11400, n);
        check_int("A4_high_len", n, 11363);
        run_len(1'b0, 11400, n);
        check_int("A4_low_len", n, 11364);
        check_bit("A4_next_rise", pwm, 1'b1);

        // Randomized stimulus against the model
        silence(15'h0000);
        m_pos = 0; m_out = 1'b0; m_prev = 15;
        cyc = 0;
        while (cyc < 7000) begin
            r_s = 1'b1;
            seglen = $urandom_range(1, 2000);
            if ($urandom_range(0, 29) == 0) begin
                r_s = 1'b0;
                seglen = $urandom_range(1, 3);
            end
            e_s = ($urandom_range(0, 9) != 0);
            if ($urandom_range(0, 9) == 0) begin
                kp_s = 15'h0000;
            end else begin
                k = $urandom_range(0, 14);
                hi = 15'($urandom);
                kp_s = (hi & (15'h7fff << (k + 1))) | (15'h0001 << k);
            end
            n_rst = r_s; en = e_s; keypad = kp_s;
            for (int c = 0; c < seglen; c++) begin
                step();
                model_edge(r_s, e_s, kp_s);
                check_bit("random", pwm, m_out);
            end
            cyc += seglen;
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/synth_top.md
# synth_top

Single-voice square-wave tone generator for the keypad synthesizer, clocked at 10 MHz. It turns a 15-key one-hot-ish keypad vector into a 50%-duty PWM audio output at the equal-tempered pitch of the selected key, C4 through D5. It is the top of the synth datapath and drives the audio pin/filter directly.

## Interface
- NUM_KEYS, 15: keypad width.
- CNT_W, 16: period counter width; holds the largest period, 38223.
- clk  input  1  system clock, 10 MHz.
- n_rst  input  1  reset, synchronous, active-low.
- en  input  1  tone enable; 0 silences the output.
- keypad_i  input  15  key-pressed vector. Bit k is semitone k above C4. Already synchronized and debounced upstream.
- pwm_o  output  1  registered square-wave audio output.

## Operation
- Key select: the lowest-index set bit of keypad_i wins. No bit set means silence.
- Period N in clk cycles, N = round(1e7 / f), for k = 0..14: 38223, 36077, 34052, 32141, 30337, 28635, 27027, 25511, 24079, 22727, 21452, 20248, 19111, 18039, 17026. The selected period is a combinational lookup.
- State:
  - cnt[CNT_W-1:0]
  - pwm_o register
  - prev_sel[3:0], used only when SYNTH_RESTART_EN is defined.
- Each rising edge, in priority order:
  - n_rst=0: cnt<=0, pwm_o<=0.
  - en=0 or no key pressed: cnt<=0, pwm_o<=0.
  - Otherwise: pwm_o <= (cnt < N>>1); cnt <= (cnt >= N-1) ? 0 : cnt+1.
- Output pattern: high for floor(N/2) cycles, then low for N-floor(N/2) cycles, repeating with period exactly N.
- Key change while active, without SYNTH_RESTART_EN: cnt keeps running. If cnt ≥ new N-1, cnt wraps to 0 on the next edge.
- Reset or en deassertion mid-period: output is 0 on the next edge and the phase restarts from cnt=0.

## Timing
- Reset value: pwm_o=0, cnt=0.
- Latency: the first rising edge sampling en=1 with a key held drives pwm_o=1. The falling edge follows floor(N/2) cycles later.
- Key selection and en take effect on the next rising edge. No input registering.
- pwm_o is glitch-free: driven directly from a flop.

## Configuration
- SYNTH_RESTART_EN defined:
  - A change of the selected key index versus prev_sel forces cnt<=0 and pwm_o<=1 on that edge, so the new note starts cleanly at phase 0.
  - prev_sel updates every edge and resets to 15, meaning "none".
- SYNTH_RESTART_EN undefined:
  - No prev_sel register.
  - Counter continues across key changes, per the wrap rule above.

## Structure
- Package synth_pkg holds:
  - NUM_KEYS and CNT_W.
  - The 15-entry period constant array NOTE_PERIOD[0:14].
  - A function returning floor(N/2).
- Sub-module tone_divider:
  - Ports: clk, n_rst, run, period[CNT_W-1:0], restart, pwm_o.
  - Implements the counter and compare.
- synth_top contains:
  - The priority encoder (keypad_i → index and valid).
  - The NOTE_PERIOD lookup.
  - Optional restart detection.

## Test plan
- Reset: n_rst=0 for 2 cycles with en=1 and keypad_i[0]=1 → pwm_o=0 throughout. After release with en=0, pwm_o stays 0.
- Low C: en=1, keypad_i=15'h0001 for 38223×3 cycles → pwm_o high 19111 cycles, low 19112 cycles, period 38223.
- A4: keypad_i=15'h0200 (bit 9) → period 22727, high 11363, low 11364.
- C5: keypad_i=15'h1000 (bit 12) → period 19111. Also keypad_i=15'h1001 → bit 0 wins, period 38223.
- Disable and no-key: drop en mid-high-phase → pwm_o=0 next edge. Re-assert → pwm_o=1 next edge, fresh phase. en=1 with keypad_i=0 → pwm_o stays 0.
- Key change from bit 0 to bit 14 while cnt ≈ 30000:
  - With SYNTH_RESTART_EN: immediate restart, period 17026 from that edge.
  - Without it: cnt wraps to 0 on the next edge, then period 17026.
